// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side signal bundle for the branch prediction / redirect controller.
// Fetch-stage lookup, Execute-stage resolution, redirect/flush and statistics.
interface branch_predict_ctrl_if;
  // Fetch-stage lookup
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  // Execute-stage resolution inputs
  logic        ValidE;
  logic        BranchE;
  logic        JumpE;
  logic        ZeroE;
  logic [2:0]  funct3E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  // Redirect and flush
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;
  // Statistics
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  // Pipeline side: drives PCs and resolution info, consumes predictions/redirects.
  modport master (
    output PCF, ValidE, BranchE, JumpE, ZeroE, funct3E, PCE, PCPlus4E,
           PCTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, FlushD, FlushE,
           BranchCount, MispredictCount
  );

  // Controller side.
  modport slave (
    input  PCF, ValidE, BranchE, JumpE, ZeroE, funct3E, PCE, PCPlus4E,
           PCTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, FlushD, FlushE,
           BranchCount, MispredictCount
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and redirect controller for a 5-stage RISC-V pipeline.
// A direct-mapped branch target table is looked up at Fetch (zero latency),
// branches/jumps are resolved at Execute, and the table is trained on the
// clock edge. The lookup sees pre-edge table contents (no write bypass).
module branch_predict_ctrl #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_ctrl_if.slave  bp
);

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Branch target table
  logic              r_valid   [ENTRIES];
  logic [TAG_W-1:0]  r_tag     [ENTRIES];
  logic [31:0]       r_target  [ENTRIES];
  logic [1:0]        r_ctr     [ENTRIES];
  logic              r_is_jump [ENTRIES];

  // Statistics
  logic [31:0]       r_br_cnt;
  logic [31:0]       r_mis_cnt;

  // Fetch lookup
  logic [IDX_W-1:0]  w_idx_f;
  logic [TAG_W-1:0]  w_tag_f;
  logic              w_hit_f;

  // Execute resolve / train
  logic [IDX_W-1:0]  w_idx_e;
  logic [TAG_W-1:0]  w_tag_e;
  logic              w_hit_e;
  logic              w_ctl_e;
  logic              w_br_taken;
  logic              w_taken;
  logic              w_mispredict;
  logic              w_unused;

  // Two-bit saturating direction counter step.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // 32-bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Instructions are word aligned; the low PC bits carry no index/tag info.
  assign w_unused = &{1'b0, bp.PCE[1:0]};

  assign w_idx_f = bp.PCF[IDX_W+1:2];
  assign w_tag_f = bp.PCF[31:IDX_W+2];
  assign w_idx_e = bp.PCE[IDX_W+1:2];
  assign w_tag_e = bp.PCE[31:IDX_W+2];

  // Fetch-stage prediction; forced quiet while reset is held.
  always_comb begin
    w_hit_f        = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    bp.PredTakenF  = 1'b0;
    bp.PredTargetF = 32'd0;
    if (rst_n) begin
      bp.PredTakenF  = w_hit_f && (r_is_jump[w_idx_f] || r_ctr[w_idx_f][1]);
      bp.PredTargetF = w_hit_f ? r_target[w_idx_f] : bp.PCF + 32'd4;
    end
  end

  // Execute-stage resolution: actual outcome, mispredict detection and redirect.
  always_comb begin
    w_hit_e    = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    w_ctl_e    = bp.BranchE | bp.JumpE;
    w_br_taken = bp.BranchE &
                 (((bp.funct3E == F3_BEQ) &  bp.ZeroE) |
                  ((bp.funct3E == F3_BNE) & ~bp.ZeroE));
    w_taken    = bp.JumpE | w_br_taken;
    // A predicted-taken non-branch (tag alias) also lands here as a mispredict.
    w_mispredict = rst_n & bp.ValidE &
                   ((bp.PredTakenE != w_taken) |
                    (bp.PredTakenE & w_taken & (bp.PredTargetE != bp.PCTargetE)));
    bp.MispredictE = w_mispredict;
    bp.FlushD      = w_mispredict;
    bp.FlushE      = w_mispredict;
    bp.RedirectPCE = 32'd0;
    if (rst_n) bp.RedirectPCE = w_taken ? bp.PCTargetE : bp.PCPlus4E;
  end

  // Table training on resolved instructions; allocation only on taken misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= '0;
        r_target[i]  <= 32'd0;
        r_ctr[i]     <= 2'b01;
        r_is_jump[i] <= 1'b0;
      end
    end else if (bp.ValidE) begin
      if (w_ctl_e) begin
        if (w_hit_e) begin
          if (bp.JumpE) begin
            r_ctr[w_idx_e]     <= 2'b11;
            r_is_jump[w_idx_e] <= 1'b1;
          end else begin
            r_ctr[w_idx_e]     <= ctr_step(r_ctr[w_idx_e], w_taken);
          end
          if (w_taken) r_target[w_idx_e] <= bp.PCTargetE;
        end else if (w_taken) begin
          r_valid[w_idx_e]   <= 1'b1;
          r_tag[w_idx_e]     <= w_tag_e;
          r_target[w_idx_e]  <= bp.PCTargetE;
          r_ctr[w_idx_e]     <= bp.JumpE ? 2'b11 : 2'b10;
          r_is_jump[w_idx_e] <= bp.JumpE;
        end
      end else if (bp.PredTakenE && w_hit_e) begin
        // Entry aliased onto a non-branch: drop it so it stops redirecting.
        r_valid[w_idx_e] <= 1'b0;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt  <= 32'd0;
      r_mis_cnt <= 32'd0;
    end else begin
      if (bp.ValidE && w_ctl_e) r_br_cnt  <= sat_inc(r_br_cnt);
      if (w_mispredict)         r_mis_cnt <= sat_inc(r_mis_cnt);
    end
  end

  assign bp.BranchCount     = r_br_cnt;
  assign bp.MispredictCount = r_mis_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed scoreboard bench for branch_predict_ctrl: expectations are queued
// when a cycle's stimulus is driven and compared once outputs have settled.
module tb_branch_predict_ctrl;

  logic clk;
  logic rst_n;

  branch_predict_ctrl_if bp_if ();

  branch_predict_ctrl #(.ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_PTF, S_PTGT, S_MIS, S_RED, S_FD, S_FE, S_BC, S_MC} sig_e;
  typedef struct {
    sig_e        sig;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input sig_e s);
    case (s)
      S_PTF:   return {31'd0, bp_if.PredTakenF};
      S_PTGT:  return bp_if.PredTargetF;
      S_MIS:   return {31'd0, bp_if.MispredictE};
      S_RED:   return bp_if.RedirectPCE;
      S_FD:    return {31'd0, bp_if.FlushD};
      S_FE:    return {31'd0, bp_if.FlushE};
      S_BC:    return bp_if.BranchCount;
      default: return bp_if.MispredictCount;
    endcase
  endfunction

  task automatic push(input sig_e s, input string tag, input logic [31:0] v);
    exp_t e;
    e.sig = s; e.tag = tag; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_f(input string t, input logic taken, input logic [31:0] tgt);
    push(S_PTF,  {t, ".PredTakenF"},  {31'd0, taken});
    push(S_PTGT, {t, ".PredTargetF"}, tgt);
  endtask

  task automatic exp_e(input string t, input logic mis, input logic [31:0] red, input bit chk_red);
    push(S_MIS, {t, ".MispredictE"}, {31'd0, mis});
    push(S_FD,  {t, ".FlushD"},      {31'd0, mis});
    push(S_FE,  {t, ".FlushE"},      {31'd0, mis});
    if (chk_red) push(S_RED, {t, ".RedirectPCE"}, red);
  endtask

  task automatic exp_c(input string t, input logic [31:0] bc, input logic [31:0] mc);
    push(S_BC, {t, ".BranchCount"},     bc);
    push(S_MC, {t, ".MispredictCount"}, mc);
  endtask

  // Compare every queued expectation against the settled DUT outputs.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.sig), e.exp);
    end
  endtask

  task automatic idle_e();
    bp_if.ValidE      = 1'b0;
    bp_if.BranchE     = 1'b0;
    bp_if.JumpE       = 1'b0;
    bp_if.ZeroE       = 1'b0;
    bp_if.funct3E     = 3'b000;
    bp_if.PCE         = 32'd0;
    bp_if.PCPlus4E    = 32'd4;
    bp_if.PCTargetE   = 32'd0;
    bp_if.PredTakenE  = 1'b0;
    bp_if.PredTargetE = 32'd0;
  endtask

  task automatic drive_e(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic z, input logic [31:0] pce, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bp_if.ValidE      = 1'b1;
    bp_if.BranchE     = br;
    bp_if.JumpE       = jmp;
    bp_if.ZeroE       = z;
    bp_if.funct3E     = f3;
    bp_if.PCE         = pce;
    bp_if.PCPlus4E    = pce + 32'd4;
    bp_if.PCTargetE   = tgt;
    bp_if.PredTakenE  = ptk;
    bp_if.PredTargetE = ptgt;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle_e();
  endtask

  task automatic settle();
    #2;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_e();
    bp_if.PCF = 32'h100;
    #3;
    exp_f("rst", 1'b0, 32'h0);
    exp_e("rst", 1'b0, 32'h0, 1'b0);
    exp_c("rst", 32'd0, 32'd0);
    drain();

    // Cold table: miss predicts fall-through.
    next_cycle(); rst_n = 1'b1;
    bp_if.PCF = 32'h100;
    exp_f("cold", 1'b0, 32'h104);
    exp_c("cold", 32'd0, 32'd0);
    settle();

    // BEQ taken, unpredicted; same-cycle lookup still sees the old table.
    next_cycle();
    drive_e(1'b1, 1'b0, 3'b000, 1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    exp_f("beq_nobyp", 1'b0, 32'h104);
    exp_e("beq", 1'b1, 32'h200, 1'b1);
    settle();

    next_cycle();
    exp_f("beq_trained", 1'b1, 32'h200);
    exp_c("beq_trained", 32'd1, 32'd1);
    settle();

    // BNE not taken while predicted taken: mispredict, ctr 10->01.
    next_cycle();
    drive_e(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
    exp_e("bne1", 1'b1, 32'h104, 1'b1);
    settle();

    next_cycle();
    exp_f("bne1_after", 1'b0, 32'h200);
    exp_c("bne1_after", 32'd2, 32'd2);
    settle();

    // BNE not taken again, predicted not taken: correct, ctr 01->00.
    next_cycle();
    drive_e(1'b1, 1'b0, 3'b001, 1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    exp_e("bne2", 1'b0, 32'h104, 1'b1);
    settle();

    // Taken once more: ctr 00->01, still predicts not taken.
    next_cycle();
    drive_e(1'b1, 1'b0, 3'b000, 1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    exp_e("beq_floor", 1'b1, 32'h200, 1'b1);
    exp_c("beq_floor", 32'd3, 32'd2);
    settle();

    next_cycle();
    exp_f("ctr_floor", 1'b0, 32'h200);
    exp_c("ctr_floor", 32'd4, 32'd3);
    settle();

    // JAL at 0x300 (same index, different tag): first encounter mispredicts.
    next_cycle();
    bp_if.PCF = 32'h300;
    drive_e(1'b0, 1'b1, 3'b000, 1'b0, 32'h300, 32'h40, 1'b0, 32'h304);
    exp_f("jal1_pre", 1'b0, 32'h304);
    exp_e("jal1", 1'b1, 32'h40, 1'b1);
    settle();

    next_cycle();
    exp_f("jal1_after", 1'b1, 32'h40);
    exp_c("jal1_after", 32'd5, 32'd4);
    settle();

    // Second encounter predicted correctly.
    next_cycle();
    drive_e(1'b0, 1'b1, 3'b000, 1'b0, 32'h300, 32'h40, 1'b1, 32'h40);
    exp_e("jal2", 1'b0, 32'h40, 1'b1);
    settle();

    // Right direction, wrong target.
    next_cycle();
    drive_e(1'b0, 1'b1, 3'b000, 1'b0, 32'h300, 32'h40, 1'b1, 32'h48);
    exp_e("jal_tgt", 1'b1, 32'h40, 1'b1);
    exp_c("jal2_after", 32'd6, 32'd4);
    settle();

    // Alias: ADD predicted taken at a hitting PC.
    next_cycle();
    drive_e(1'b0, 1'b0, 3'b000, 1'b0, 32'h300, 32'h999, 1'b1, 32'h40);
    exp_e("alias", 1'b1, 32'h304, 1'b1);
    exp_c("alias_pre", 32'd7, 32'd5);
    settle();

    next_cycle();
    exp_f("alias_inval", 1'b0, 32'h304);
    exp_c("alias_after", 32'd7, 32'd6);
    settle();

    // Bubble with arbitrary control inputs: no flush, no training, no count.
    next_cycle();
    bp_if.BranchE = 1'b1; bp_if.JumpE = 1'b1; bp_if.PredTakenE = 1'b1;
    bp_if.PCE = 32'h300; bp_if.PCTargetE = 32'h80; bp_if.PredTargetE = 32'h44;
    exp_e("bubble", 1'b0, 32'h0, 1'b0);
    settle();

    next_cycle();
    exp_f("bubble_after", 1'b0, 32'h304);
    exp_c("bubble_after", 32'd7, 32'd6);
    settle();

    // BranchE and JumpE together behave as a jump (taken despite Zero=0).
    next_cycle();
    drive_e(1'b1, 1'b1, 3'b000, 1'b0, 32'h380, 32'h500, 1'b0, 32'h384);
    exp_e("brjmp", 1'b1, 32'h500, 1'b1);
    settle();

    next_cycle();
    bp_if.PCF = 32'h380;
    exp_f("brjmp_after", 1'b1, 32'h500);
    exp_c("brjmp_after", 32'd8, 32'd7);
    settle();

    // Unsupported funct3 (BLT) resolves as not taken.
    next_cycle();
    drive_e(1'b1, 1'b0, 3'b100, 1'b0, 32'h104, 32'h700, 1'b0, 32'h108);
    exp_e("blt", 1'b0, 32'h108, 1'b1);
    settle();

    // Statistics saturate at all-ones.
    next_cycle();
    force dut.r_mis_cnt = 32'hFFFF_FFFF;
    force dut.r_br_cnt  = 32'hFFFF_FFFF;
    #1;
    release dut.r_mis_cnt;
    release dut.r_br_cnt;
    drive_e(1'b1, 1'b0, 3'b000, 1'b1, 32'h104, 32'h210, 1'b0, 32'h108);
    exp_e("sat", 1'b1, 32'h210, 1'b1);
    exp_c("sat_pre", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle();

    next_cycle();
    exp_c("sat_after", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle();

    // Reset asserted mid-cycle during a mispredict.
    next_cycle();
    bp_if.PCF = 32'h380;
    drive_e(1'b0, 1'b1, 3'b000, 1'b0, 32'h380, 32'h500, 1'b0, 32'h384);
    exp_f("prerst", 1'b1, 32'h500);
    exp_e("prerst", 1'b1, 32'h500, 1'b1);
    settle();
    #1;
    rst_n = 1'b0;
    #1;
    exp_f("midrst", 1'b0, 32'h0);
    exp_e("midrst", 1'b0, 32'h0, 1'b0);
    exp_c("midrst", 32'd0, 32'd0);
    drain();

    next_cycle();
    rst_n = 1'b1;
    exp_f("postrst", 1'b0, 32'h384);
    exp_c("postrst", 32'd0, 32'd0);
    settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
